// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole design.
// Contents:
//   flash_state_t - LED flasher sequence states (IDLE, ON, OFF)
//   TICK_1MS      - clk cycles per 1 ms tick at 100 MHz
//   FLASH_ON      - default lit time per flash, in ticks
//   FLASH_OFF     - default dark time between flashes, in ticks
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } flash_state_t;

    localparam int unsigned TICK_1MS  = 100000;
    localparam int unsigned FLASH_ON  = 200;
    localparam int unsigned FLASH_OFF = 200;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clk cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   clr   - restarts the prescaler at count 0
//   tick  - high for one cycle when the count reaches CLK_DIV-1
module tick_gen #(
    parameter int unsigned CLK_DIV = whack_pkg::TICK_1MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/led_flasher.sv
// Turns a one-cycle event pulse into a sequence of BLINKS visible flashes.
// Each flash is lit for ON_TICKS ticks, separated by OFF_TICKS dark ticks;
// there is no trailing dark phase after the last flash.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - synchronous active-low reset
//   trigger - one-cycle start pulse; restarts the sequence when busy
//   cancel  - one-cycle abort pulse; wins over trigger
//   led     - LED drive, active high, registered
//   busy    - high while a sequence is in progress, registered
module led_flasher
    import whack_pkg::*;
#(
    parameter int unsigned CLK_DIV   = TICK_1MS,
    parameter int unsigned ON_TICKS  = FLASH_ON,
    parameter int unsigned OFF_TICKS = FLASH_OFF,
    parameter int unsigned BLINKS    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    input  logic cancel,
    output logic led,
    output logic busy
);

    localparam int unsigned MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned PW   = $clog2(MAXT + 1);
    localparam int unsigned BW   = (BLINKS > 1) ? $clog2(BLINKS) : 1;

    localparam logic [PW-1:0] ON_LAST    = PW'(ON_TICKS - 1);
    localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_TICKS - 1);
    localparam logic [BW-1:0] BLINK_INIT = BW'(BLINKS - 1);

    flash_state_t  state, state_nxt;
    logic [PW-1:0] phase;
    logic [BW-1:0] blink;
    logic          tick;
    logic          restart;
    logic          clr;
    logic          blink_load;
    logic          blink_dec;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_nxt  = state;
        restart    = 1'b0;
        blink_load = 1'b0;
        blink_dec  = 1'b0;
        if (cancel) begin
            state_nxt = IDLE;
        end else if (trigger) begin
            state_nxt  = ON;
            restart    = 1'b1;
            blink_load = 1'b1;
        end else begin
            case (state)
                ON: begin
                    if (tick && phase == ON_LAST) begin
                        restart   = 1'b1;
                        state_nxt = (blink != '0) ? OFF : IDLE;
                    end
                end
                OFF: begin
                    if (tick && phase == OFF_LAST) begin
                        restart   = 1'b1;
                        state_nxt = ON;
                        blink_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Holding the counters clear while idle means a cancel needs no
        // explicit clear: the next entry to ON starts from zero anyway.
        clr = restart || (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= '0;
            blink <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            led   <= (state_nxt == ON);
            busy  <= (state_nxt != IDLE);
            if (clr) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase + PW'(1);
            end
            if (blink_load) begin
                blink <= BLINK_INIT;
            end else if (blink_dec) begin
                blink <= blink - BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_flasher.sv
module tb_led_flasher;

    localparam int unsigned A_DIV = 2, A_ON = 3, A_OFF = 2, A_BL = 2;
    localparam int unsigned B_DIV = 1, B_ON = 1, B_OFF = 1, B_BL = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic trigger = 1'b0;
    logic cancel  = 1'b0;
    logic led_a, busy_a, led_b, busy_b;

    led_flasher #(
        .CLK_DIV   (A_DIV),
        .ON_TICKS  (A_ON),
        .OFF_TICKS (A_OFF),
        .BLINKS    (A_BL)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .cancel  (cancel),
        .led     (led_a),
        .busy    (busy_a)
    );

    led_flasher #(
        .CLK_DIV   (B_DIV),
        .ON_TICKS  (B_ON),
        .OFF_TICKS (B_OFF),
        .BLINKS    (B_BL)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .cancel  (cancel),
        .led     (led_b),
        .busy    (busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: a sequence is alive from the edge that accepted the last
    // trigger; outputs follow from elapsed cycles by plain arithmetic.
    bit active = 1'b0;
    int start  = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, obs, exp);
        end
    endtask

    function automatic void ref_outs(input int d, input int on_t, input int off_t,
                                     input int blinks, output logic led, output logic busy);
        int e, total, period;
        e      = cyc - start;
        total  = (blinks * on_t + (blinks - 1) * off_t) * d;
        period = (on_t + off_t) * d;
        busy   = active && (e < total);
        led    = busy && ((e % period) < on_t * d);
    endfunction

    task automatic step(input logic r, input logic t, input logic c);
        logic el, eb;
        @(negedge clk);
        rst_n   = r;
        trigger = t;
        cancel  = c;
        @(posedge clk);
        cyc++;
        if (!r || c) begin
            active = 1'b0;
        end else if (t) begin
            active = 1'b1;
            start  = cyc;
        end
        #1;
        ref_outs(A_DIV, A_ON, A_OFF, A_BL, el, eb);
        check("led_a", led_a, el);
        check("busy_a", busy_a, eb);
        ref_outs(B_DIV, B_ON, B_OFF, B_BL, el, eb);
        check("led_b", led_b, el);
        check("busy_b", busy_b, eb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        // basic sequence
        step(1'b1, 1'b1, 1'b0);
        idle(20);
        // reset mid-ON, then fresh trigger
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b1, 1'b0);
        idle(20);
        // retrigger during OFF
        step(1'b1, 1'b1, 1'b0);
        idle(8);
        step(1'b1, 1'b1, 1'b0);
        idle(20);
        // cancel mid-ON, then trigger+cancel together in IDLE
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b1, 1'b1);
        idle(5);
        // back-to-back triggers
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(20);
        // trigger held for several cycles
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        idle(20);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 29) == 0));
        end
        idle(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
